// File: rtl/time_entry_pkg.sv
// Shared key map, edge-event record, FSM state type and width helpers for the
// keypad time-entry controller.
package time_entry_pkg;

   localparam int NUM_KEYS  = 12;
   localparam int KEY_ZERO  = 9;
   localparam int KEY_CLEAR = 10;
   localparam int KEY_ENTER = 11;

   typedef enum logic {
      ENTRY,
      CONVERT
   } state_e;

   // One cycle's worth of decoded keypad activity after priority resolution.
   typedef struct packed {
      logic       valid;
      logic       clear;
      logic       enter;
      logic [3:0] digit;
   } key_ev_t;

   function automatic logic [3:0] key_to_digit(input int idx);
      return (idx == KEY_ZERO) ? 4'd0 : 4'(idx + 1);
   endfunction

   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Bits needed for a field of the given number of decimal digits.
   function automatic int field_width(input int digits);
      return $clog2(pow10(digits));
   endfunction

   // Bits needed to count from 0 up to and including n.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/key_edge_encoder.sv
// Registers the debounced key levels, extracts rising edges and resolves them
// into a single event: CLEAR over ENTER over the lowest-index digit.
module key_edge_encoder
   import time_entry_pkg::*;
(
   input  logic                I2C_clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] button_ord,
   output key_ev_t             key_ev
);

   logic [NUM_KEYS-1:0] key_q, key_d;
   logic [NUM_KEYS-1:0] edges;

   // NOTE: every signal assigned in always_comb gets a value before any branch, so no latch can be inferred.
   always_comb begin
      key_d        = button_ord;
      edges        = button_ord & ~key_q;
      key_ev.valid = |edges;
      key_ev.clear = edges[KEY_CLEAR];
      key_ev.enter = edges[KEY_ENTER];
      key_ev.digit = 4'd0;
      // Scan downwards so the lowest-index digit edge is the one that sticks.
      for (int i = KEY_ZERO; i >= 0; i--) begin
         if (edges[i]) key_ev.digit = key_to_digit(i);
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge I2C_clk) begin
      if (rst) key_q <= '0;
      else     key_q <= key_d;
   end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad mm:ss entry controller: edit buffer with cursor and range check, then a
// digit-serial BCD->binary conversion that publishes committed values with a strobe.
module time_entry_ctrl
   import time_entry_pkg::*;
#(
   parameter  int NUM_FIELDS       = 2,
   parameter  int DIGITS_PER_FIELD = 2,
   parameter  int MINOR_TENS_MAX   = 5,
   localparam int ND               = NUM_FIELDS * DIGITS_PER_FIELD,
   localparam int FW               = field_width(DIGITS_PER_FIELD),
   localparam int CW               = count_width(ND)
) (
   input  logic                     I2C_clk,
   input  logic                     rst,
   input  logic [NUM_KEYS-1:0]      button_ord,
   output logic [4*ND-1:0]          entry_bcd,
   output logic [CW-1:0]            cursor,
   output logic                     busy,
   output logic [4*ND-1:0]          commit_bcd,
   output logic [NUM_FIELDS*FW-1:0] commit_bin,
   output logic                     commit_stb,
   output logic                     reject_stb
);

   localparam int             SW  = NUM_FIELDS * FW;
   localparam int             PW  = count_width(DIGITS_PER_FIELD);
   localparam logic [FW-1:0]  TEN = FW'(10);

   key_ev_t key_ev;

   key_edge_encoder u_key_edge_encoder (
      .I2C_clk    (I2C_clk),
      .rst        (rst),
      .button_ord (button_ord),
      .key_ev     (key_ev)
   );

   state_e          state_q, state_d;
   logic [4*ND-1:0] entry_q, entry_d;
   logic [CW-1:0]   cursor_q, cursor_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [FW-1:0]   acc_q, acc_d;
   logic [SW-1:0]   shadow_q, shadow_d;
   logic [4*ND-1:0] commit_bcd_q, commit_bcd_d;
   logic [SW-1:0]   commit_bin_q, commit_bin_d;
   logic            commit_stb_q, commit_stb_d;
   logic            reject_stb_q, reject_stb_d;

   logic [3:0]      conv_digit;
   logic [FW-1:0]   acc_base;
   logic [FW-1:0]   acc_next;

   // True when the slot is the leading (tens) digit of any field after field 0.
   function automatic logic minor_lead(input logic [CW-1:0] slot);
      logic hit;
      hit = 1'b0;
      for (int f = 1; f < NUM_FIELDS; f++) begin
         if (int'(slot) == f * DIGITS_PER_FIELD) hit = 1'b1;
      end
      return hit;
   endfunction

   // Datapath for one conversion step: fetch the indexed digit and fold it in.
   always_comb begin
      conv_digit = 4'd0;
      for (int i = 0; i < ND; i++) begin
         if (int'(idx_q) == i) conv_digit = entry_q[(ND-1-i)*4 +: 4];
      end
      acc_base = (pos_q == '0) ? '0 : acc_q;
      acc_next = acc_base * TEN + FW'(conv_digit);
   end

   always_comb begin
      state_d      = state_q;
      entry_d      = entry_q;
      cursor_d     = cursor_q;
      idx_d        = idx_q;
      pos_d        = pos_q;
      acc_d        = acc_q;
      shadow_d     = shadow_q;
      commit_bcd_d = commit_bcd_q;
      commit_bin_d = commit_bin_q;
      commit_stb_d = 1'b0;
      reject_stb_d = 1'b0;

      case (state_q)
         ENTRY: begin
            if (key_ev.clear) begin
               entry_d  = '0;
               cursor_d = '0;
            end else if (key_ev.enter) begin
               state_d = CONVERT;
               idx_d   = '0;
               pos_d   = '0;
            end else if (key_ev.valid) begin
               if (int'(cursor_q) == ND) begin
                  reject_stb_d = 1'b1;
               end else if (minor_lead(cursor_q) && key_ev.digit > 4'(MINOR_TENS_MAX)) begin
                  reject_stb_d = 1'b1;
               end else begin
                  for (int i = 0; i < ND; i++) begin
                     if (int'(cursor_q) == i) entry_d[(ND-1-i)*4 +: 4] = key_ev.digit;
                  end
                  cursor_d = cursor_q + 1'b1;
               end
            end
         end

         CONVERT: begin
            if (key_ev.clear) begin
               // Abort leaves commit_* untouched; partial results only live in shadow.
               state_d  = ENTRY;
               entry_d  = '0;
               cursor_d = '0;
            end else if (int'(idx_q) == ND) begin
               commit_bin_d = shadow_q;
               commit_bcd_d = entry_q;
               commit_stb_d = 1'b1;
               entry_d      = '0;
               cursor_d     = '0;
               state_d      = ENTRY;
            end else begin
               acc_d = acc_next;
               idx_d = idx_q + 1'b1;
               if (int'(pos_q) == DIGITS_PER_FIELD - 1) begin
                  // Fields complete in order, so shifting leaves field 0 in the MSBs.
                  shadow_d = (shadow_q << FW) | SW'(acc_next);
                  pos_d    = '0;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
         end
      endcase
   end

   // NOTE: the reset is synchronous and clears every register, including shadow and commit values, so no stale data is visible after reset.
   always_ff @(posedge I2C_clk) begin
      if (rst) begin
         state_q      <= ENTRY;
         entry_q      <= '0;
         cursor_q     <= '0;
         idx_q        <= '0;
         pos_q        <= '0;
         acc_q        <= '0;
         shadow_q     <= '0;
         commit_bcd_q <= '0;
         commit_bin_q <= '0;
         commit_stb_q <= 1'b0;
         reject_stb_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         entry_q      <= entry_d;
         cursor_q     <= cursor_d;
         idx_q        <= idx_d;
         pos_q        <= pos_d;
         acc_q        <= acc_d;
         shadow_q     <= shadow_d;
         commit_bcd_q <= commit_bcd_d;
         commit_bin_q <= commit_bin_d;
         commit_stb_q <= commit_stb_d;
         reject_stb_q <= reject_stb_d;
      end
   end

   assign entry_bcd  = entry_q;
   assign cursor     = cursor_q;
   assign busy       = (state_q == CONVERT);
   assign commit_bcd = commit_bcd_q;
   assign commit_bin = commit_bin_q;
   assign commit_stb = commit_stb_q;
   assign reject_stb = reject_stb_q;

endmodule
